// File: rtl/oneapi_gasket_pkg.sv
// Shared types and the channel remap helper for the oneAPI Avalon-ST to AXI4-S video gasket.
package oneapi_gasket_pkg;

   typedef enum logic {
      SYNC = 1'b0,
      RUN  = 1'b1
   } gasket_state_e;

   // Widest channel the remap helper handles on either side of the gasket.
   localparam int MAX_CH_W = 32;

   typedef struct packed {
      logic tlast;
      logic sof;
   } beat_meta_t;

   localparam int BEAT_META_W = $bits(beat_meta_t);

   function automatic logic [MAX_CH_W-1:0] remap_channel(
      input logic [MAX_CH_W-1:0] av_ch,
      input logic [MAX_CH_W-1:0] mask
   );
      return av_ch & mask;
   endfunction

endpackage

// File: rtl/oneapi_gasket_skid_buffer.sv
// Two-entry skid buffer: head entry drives the downstream payload straight from flops,
// upstream ready is registered from the next occupancy.
module oneapi_gasket_skid_buffer #(
   parameter int W = 26
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] din,
   output logic         in_ready,
   output logic         out_valid,
   output logic [W-1:0] dout,
   input  logic         out_ready
);

   logic [1:0]   count_q;
   logic [1:0]   count_d;
   logic [W-1:0] head_q;
   logic [W-1:0] tail_q;
   logic         valid_q;
   logic         pop;

   assign pop       = valid_q & out_ready;
   assign out_valid = valid_q;
   assign dout      = head_q;

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q  <= 2'd0;
         valid_q  <= 1'b0;
         in_ready <= 1'b0;
         head_q   <= '0;
         tail_q   <= '0;
      end else begin
         count_q  <= count_d;
         valid_q  <= (count_d != 2'd0);
         in_ready <= (count_d < 2'd2);
         // Head takes the new beat when it would otherwise be empty; else it refills from tail.
         if (push && ((count_q == 2'd0) || ((count_q == 2'd1) && pop)))
            head_q <= din;
         else if (pop && (count_q == 2'd2))
            head_q <= tail_q;
         if (push && (((count_q == 2'd1) && !pop) || ((count_q == 2'd2) && pop)))
            tail_q <= din;
      end
   end

endmodule

// File: rtl/oneapi_avs_to_axs_pixel_gasket.sv
// Return-path gasket: oneAPI Avalon-ST source to Intel Streaming Video AXI4-S transmitter.
// Strips channel padding, maps SOP/EOP to tuser[0]/tlast and waits for the first frame start.
module oneapi_avs_to_axs_pixel_gasket
   import oneapi_gasket_pkg::*;
#(
   parameter int                  PARALLEL_PIXELS      = 1,
   parameter int                  BITS_PER_CHANNEL     = 8,
   parameter int                  CHANNELS             = 3,
   parameter int                  BITS_PER_CHANNEL_AV  = 8,
   parameter int                  BITS_PER_PIXEL_AV    = 24,
   parameter int                  BITS_AV              = 24,
   parameter int                  EMPTY_BITS           = 2,
   parameter int                  BITS_PER_CHANNEL_AXI = 8,
   parameter int                  BITS_PER_PIXEL_AXI   = 24,
   parameter int                  BITS_AXI             = 24,
   parameter int                  TUSER_BITS           = 3,
   parameter logic [MAX_CH_W-1:0] MASK_IN              = 'hff
) (
   input  logic                  csi_clk,
   input  logic                  rsi_reset,
   output logic                  asi_ready,
   input  logic                  asi_valid,
   input  logic [BITS_AV-1:0]    asi_data,
   input  logic                  asi_startofpacket,
   input  logic                  asi_endofpacket,
   input  logic [EMPTY_BITS-1:0] asi_empty,
   input  logic                  axm_tready,
   output logic                  axm_tvalid,
   output logic [BITS_AXI-1:0]   axm_tdata,
   output logic                  axm_tlast,
   output logic [TUSER_BITS-1:0] axm_tuser,
   output logic                  status_synced,
   output logic                  status_sop_err
);

   typedef struct packed {
      logic [BITS_AXI-1:0] tdata;
      beat_meta_t          meta;
   } beat_t;

   gasket_state_e       state_q;
   gasket_state_e       state_d;
   logic                accept;
   logic                push;
   logic                buf_ready;
   logic                mid_line_q;
   logic                synced_q;
   logic                sop_err_q;
   logic [BITS_AXI-1:0] remapped;
   beat_t               beat_in;
   beat_t               beat_out;
   logic                unused_inputs;

   // Empty is meaningless for video beats; significant width is implied by the mask.
   assign unused_inputs = ^{asi_empty, asi_data, 1'(BITS_PER_CHANNEL)};

   assign asi_ready = buf_ready;
   assign accept    = asi_valid & buf_ready;

   always_comb begin
      remapped = '0;
      for (int p = 0; p < PARALLEL_PIXELS; p++) begin
         for (int c = 0; c < CHANNELS; c++) begin
            remapped[p*BITS_PER_PIXEL_AXI + c*BITS_PER_CHANNEL_AXI +: BITS_PER_CHANNEL_AXI] =
               BITS_PER_CHANNEL_AXI'(remap_channel(
                  MAX_CH_W'(asi_data[p*BITS_PER_PIXEL_AV + c*BITS_PER_CHANNEL_AV +: BITS_PER_CHANNEL_AV]),
                  MASK_IN));
         end
      end
   end

   always_comb begin
      beat_in            = '0;
      beat_in.tdata      = remapped;
      beat_in.meta.tlast = asi_endofpacket;
      beat_in.meta.sof   = asi_startofpacket;
   end

   always_comb begin
      state_d = state_q;
      push    = 1'b0;
      case (state_q)
         SYNC: begin
            // The frame-start beat that ends synchronisation is itself forwarded.
            if (accept && asi_startofpacket) begin
               push    = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            push = accept;
         end
         default: begin
            state_d = SYNC;
         end
      endcase
   end

   always_ff @(posedge csi_clk or posedge rsi_reset) begin
      if (rsi_reset) begin
         state_q    <= SYNC;
         synced_q   <= 1'b0;
         mid_line_q <= 1'b0;
         sop_err_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         synced_q <= (state_d == RUN);
         if (push) begin
            mid_line_q <= !asi_endofpacket;
            if (asi_startofpacket && mid_line_q)
               sop_err_q <= 1'b1;
         end
      end
   end

   oneapi_gasket_skid_buffer #(
      .W($bits(beat_t))
   ) u_skid (
      .clk       (csi_clk),
      .rst       (rsi_reset),
      .push      (push),
      .din       (beat_in),
      .in_ready  (buf_ready),
      .out_valid (axm_tvalid),
      .dout      (beat_out),
      .out_ready (axm_tready)
   );

   assign axm_tdata      = beat_out.tdata;
   assign axm_tlast      = beat_out.meta.tlast;
   assign axm_tuser      = TUSER_BITS'(beat_out.meta.sof);
   assign status_synced  = synced_q;
   assign status_sop_err = sop_err_q;

endmodule

// File: tb/tb_oneapi_avs_to_axs_pixel_gasket.sv
// Bench for the Avalon-ST to AXI4-S gasket: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the gasket's stream behaviour.
module tb_oneapi_avs_to_axs_pixel_gasket;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        asi_ready, asi_valid, asi_sop, asi_eop;
   logic [23:0] asi_data;
   logic [1:0]  asi_empty;
   logic        axm_tready, axm_tvalid, axm_tlast;
   logic [23:0] axm_tdata;
   logic [2:0]  axm_tuser;
   logic        status_synced, status_sop_err;

   logic        w_ready, w_valid, w_sop, w_eop;
   logic [59:0] w_data;
   logic [1:0]  w_empty;
   logic        w_tready, w_tvalid, w_tlast;
   logic [47:0] w_tdata;
   logic [2:0]  w_tuser;
   logic        w_synced, w_sop_err;

   oneapi_avs_to_axs_pixel_gasket dut (
      .csi_clk           (clk),
      .rsi_reset         (rst),
      .asi_ready         (asi_ready),
      .asi_valid         (asi_valid),
      .asi_data          (asi_data),
      .asi_startofpacket (asi_sop),
      .asi_endofpacket   (asi_eop),
      .asi_empty         (asi_empty),
      .axm_tready        (axm_tready),
      .axm_tvalid        (axm_tvalid),
      .axm_tdata         (axm_tdata),
      .axm_tlast         (axm_tlast),
      .axm_tuser         (axm_tuser),
      .status_synced     (status_synced),
      .status_sop_err    (status_sop_err)
   );

   oneapi_avs_to_axs_pixel_gasket #(
      .PARALLEL_PIXELS      (2),
      .BITS_PER_CHANNEL     (8),
      .CHANNELS             (3),
      .BITS_PER_CHANNEL_AV  (10),
      .BITS_PER_PIXEL_AV    (30),
      .BITS_AV              (60),
      .EMPTY_BITS           (2),
      .BITS_PER_CHANNEL_AXI (8),
      .BITS_PER_PIXEL_AXI   (24),
      .BITS_AXI             (48),
      .TUSER_BITS           (3),
      .MASK_IN              (32'hff)
   ) dut_wide (
      .csi_clk           (clk),
      .rsi_reset         (rst),
      .asi_ready         (w_ready),
      .asi_valid         (w_valid),
      .asi_data          (w_data),
      .asi_startofpacket (w_sop),
      .asi_endofpacket   (w_eop),
      .asi_empty         (w_empty),
      .axm_tready        (w_tready),
      .axm_tvalid        (w_tvalid),
      .axm_tdata         (w_tdata),
      .axm_tlast         (w_tlast),
      .axm_tuser         (w_tuser),
      .status_synced     (w_synced),
      .status_sop_err    (w_sop_err)
   );

   typedef struct {
      logic [23:0] data;
      logic        last;
      logic        sof;
   } exp_beat_t;

   exp_beat_t exp_q[$];
   bit        m_synced, m_mid, m_err;
   int        tests_run    = 0;
   int        tests_failed = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Channel extraction, masking and repacking written as plain shifts over the pixel grid.
   function automatic logic [63:0] ref_remap(input logic [63:0] d, input int pp, input int ch,
                                             input int cav, input int pav, input int cax, input int pax);
      logic [63:0] r;
      logic [63:0] v;
      r = '0;
      for (int p = 0; p < pp; p++) begin
         for (int c = 0; c < ch; c++) begin
            v = (d >> (p*pav + c*cav)) & ((64'd1 << cav) - 64'd1);
            v = v & 64'hff & ((64'd1 << cax) - 64'd1);
            r = r | (v << (p*pax + c*cax));
         end
      end
      return r;
   endfunction

   task automatic drive(input bit v, input logic [23:0] d, input bit s, input bit e, input bit tr);
      asi_valid  = v;
      asi_data   = d;
      asi_sop    = s;
      asi_eop    = e;
      axm_tready = tr;
      asi_empty  = 2'($urandom_range(0, 3));
   endtask

   // One clock: apply the handshakes seen before the edge to the model, then check after it.
   task automatic cycle();
      logic        pre_rdy, pre_tv, pre_tr, pre_last;
      logic [23:0] pre_td;
      logic [2:0]  pre_tu;
      logic [63:0] rm;
      exp_beat_t   b;
      pre_rdy  = asi_ready;
      pre_tv   = axm_tvalid;
      pre_tr   = axm_tready;
      pre_td   = axm_tdata;
      pre_last = axm_tlast;
      pre_tu   = axm_tuser;
      @(posedge clk);
      if (pre_tv && pre_tr) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_beat", 64'd1, 64'd0);
         end else begin
            b = exp_q.pop_front();
            chk("tdata", 64'(pre_td), 64'(b.data));
            chk("tlast", 64'(pre_last), 64'(b.last));
            chk("tuser", 64'(pre_tu), {61'd0, 2'b00, b.sof});
         end
      end
      if (asi_valid && pre_rdy && (m_synced || asi_sop)) begin
         if (asi_sop && m_mid) m_err = 1'b1;
         m_synced = 1'b1;
         m_mid    = !asi_eop;
         rm       = ref_remap({40'd0, asi_data}, 1, 3, 8, 24, 8, 24);
         b.data   = rm[23:0];
         b.last   = asi_eop;
         b.sof    = asi_sop;
         exp_q.push_back(b);
      end
      @(negedge clk);
      chk("tvalid", 64'(axm_tvalid), 64'(exp_q.size() != 0));
      chk("asi_ready", 64'(asi_ready), 64'(exp_q.size() < 2));
      chk("synced", 64'(status_synced), 64'(m_synced));
      chk("sop_err", 64'(status_sop_err), 64'(m_err));
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_tvalid"}, 64'(axm_tvalid), 64'd0);
      chk({tag, "_ready"}, 64'(asi_ready), 64'd0);
      chk({tag, "_tdata"}, 64'(axm_tdata), 64'd0);
      chk({tag, "_tlast_tuser"}, 64'({axm_tlast, axm_tuser}), 64'd0);
      chk({tag, "_status"}, 64'({status_synced, status_sop_err}), 64'd0);
      chk({tag, "_wide_tvalid"}, 64'(w_tvalid), 64'd0);
   endtask

   task automatic clear_model();
      exp_q.delete();
      m_synced = 1'b0;
      m_mid    = 1'b0;
      m_err    = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      drive(0, 24'd0, 0, 0, 1);
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      clear_model();
      cycle();
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst      = 1'b1;
      w_valid  = 1'b0;
      w_data   = '0;
      w_sop    = 1'b0;
      w_eop    = 1'b0;
      w_empty  = 2'd0;
      w_tready = 1'b1;
      drive(0, 24'd0, 0, 0, 1);
      clear_model();
      do_reset();

      // Test 1: beats before the first SOP are dropped
      drive(1, 24'h112233, 0, 0, 1); cycle();
      drive(1, 24'h445566, 0, 0, 1); cycle();
      drive(1, 24'hAABBCC, 1, 1, 1); cycle();
      chk("t1_tdata", 64'(axm_tdata), 64'hAABBCC);
      chk("t1_tuser", 64'(axm_tuser), 64'h1);
      chk("t1_synced", 64'(status_synced), 64'h1);
      drive(0, 24'd0, 0, 0, 1); cycle();

      // Test 2: four-beat line at full rate, one cycle latency
      for (int i = 0; i < 4; i++) begin
         drive(1, 24'h100000 + 24'(i * 24'h010203), 0, (i == 3), 1);
         cycle();
         chk("t2_lat_tdata", 64'(axm_tdata), 64'(24'h100000 + 24'(i * 24'h010203)));
         chk("t2_lat_tlast", 64'(axm_tlast), 64'(i == 3));
      end
      drive(0, 24'd0, 0, 0, 1); cycle();

      // Test 3: downstream stall for five cycles with continuous input
      for (int i = 0; i < 12; i++) begin
         drive(1, 24'h300000 + 24'(i), 0, (i == 11), !(i >= 2 && i < 7));
         cycle();
         if (i == 5) chk("t3_ready_low", 64'(asi_ready), 64'd0);
      end
      for (int i = 0; i < 3; i++) begin
         drive(0, 24'd0, 0, 0, 1); cycle();
      end

      // Test 4: wide configuration, 10-bit padded channels into 8-bit lanes
      @(negedge clk);
      w_data  = {10'h100, 10'h3A5, 10'h0C3, 10'h2FF, 10'h155, 10'h3A5};
      w_valid = 1'b1;
      w_sop   = 1'b1;
      w_eop   = 1'b1;
      chk("t4_ready", 64'(w_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      w_valid = 1'b0;
      chk("t4_tvalid", 64'(w_tvalid), 64'd1);
      chk("t4_lane0", 64'(w_tdata[7:0]), 64'hA5);
      chk("t4_lane4", 64'(w_tdata[39:32]), 64'hA5);
      chk("t4_tdata", 64'(w_tdata), 64'h00A5C3FF55A5);
      chk("t4_model", 64'(w_tdata), ref_remap({4'd0, 10'h100, 10'h3A5, 10'h0C3, 10'h2FF, 10'h155, 10'h3A5},
                                               2, 3, 10, 30, 8, 24));
      chk("t4_tuser_tlast", 64'({w_tuser, w_tlast}), 64'b0011);
      @(negedge clk);
      chk("t4_drained", 64'(w_tvalid), 64'd0);

      // Test 5: SOP arriving mid-line
      drive(1, 24'h500001, 0, 0, 1); cycle();
      drive(1, 24'h500002, 0, 0, 1); cycle();
      drive(1, 24'h500003, 1, 0, 1); cycle();
      chk("t5_sop_err", 64'(status_sop_err), 64'd1);
      chk("t5_tuser", 64'(axm_tuser), 64'd1);
      drive(1, 24'h500004, 0, 1, 1); cycle();
      drive(0, 24'd0, 0, 0, 1); cycle();

      // Test 6: reset while two beats are buffered
      for (int i = 0; i < 3; i++) begin
         drive(1, 24'h600000 + 24'(i), 0, 0, 0); cycle();
      end
      chk("t6_full", 64'(exp_q.size()), 64'd2);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_tvalid_async", 64'(axm_tvalid), 64'd0);
      chk("t6_ready_async", 64'(asi_ready), 64'd0);
      @(negedge clk);
      drive(0, 24'd0, 0, 0, 1);
      check_reset_outputs("t6");
      @(negedge clk);
      rst = 1'b0;
      clear_model();
      for (int i = 0; i < 3; i++) cycle();
      drive(1, 24'h700001, 0, 0, 1); cycle();
      drive(1, 24'h700002, 1, 1, 1); cycle();
      drive(0, 24'd0, 0, 0, 1); cycle();
      cycle();

      // Randomized traffic
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         drive($urandom_range(0, 9) < 7, 24'($urandom), $urandom_range(0, 9) == 0,
               $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 6);
         cycle();
      end
      for (int i = 0; i < 4; i++) begin
         drive(0, 24'd0, 0, 0, 1); cycle();
      end
      chk("rand_drained", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
